dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory between the MIPS core's data port and a DMA/loader master. CPU has default priority. A starvation counter forces bounded DMA bursts, and the CPU is stalled while it is locked out. The block sits between `mips`/`dmem` in the top level and adds no latency to CPU accesses.

## Interface
Parameters:
- `DW`, 32, data width.
- `AW`, 32, address width; passed through to `dmem` unchanged.
- `STARVE_LIMIT`, 4, consecutive cycles the DMA may wait while the CPU is granted before a DMA burst is forced (≥1).
- `MAX_BURST`, 4, maximum consecutive DMA grants in a forced burst (≥1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU data access this cycle (memread | memwrite).
- `cpu_we`  in  1  CPU write.
- `cpu_addr`  in  AW  CPU byte address (aluout).
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  read data, combinational from `mem_rd`.
- `cpu_stall`  out  1  core must hold PC/regfile this cycle.
- `dma_req`  in  1  DMA access request; held until granted.
- `dma_we`  in  1  DMA write.
- `dma_addr`  in  AW  DMA address.
- `dma_wdata`  in  DW  DMA write data.
- `dma_gnt`  out  1  DMA access performed at this clock edge.
- `dma_rdata`  out  DW  registered DMA read data.
- `dma_rvalid`  out  1  `dma_rdata` valid (one-cycle pulse).
- `mem_we`, `mem_a`, `mem_wd`  out  1/AW/DW  to `dmem`.
- `mem_rd`  in  DW  from `dmem`.

## Operation
- FSM states:
  - `CPU_PRI` (reset state).
  - `DMA_BURST`.
- `CPU_PRI` grant rule:
  - `cpu_gnt = cpu_req`.
  - `dma_gnt = dma_req & ~cpu_req`.
- `DMA_BURST` grant rule:
  - `dma_gnt = dma_req`.
  - `cpu_gnt = cpu_req & ~dma_req`.
- `cpu_stall = cpu_req & ~cpu_gnt`.
- `wait_cnt` (CPU_PRI only):
  - +1 on each edge with `dma_req & cpu_gnt`.
  - Cleared on any edge with `dma_gnt`, and when leaving CPU_PRI.
  - If `wait_cnt == STARVE_LIMIT-1` with `dma_req & cpu_gnt`: go to DMA_BURST, clear `wait_cnt`.
- `burst_cnt` (DMA_BURST only):
  - +1 on each `dma_gnt` edge.
  - If `dma_gnt` and `burst_cnt == MAX_BURST-1`: go to CPU_PRI, clear `burst_cnt`.
  - If `~dma_req` in DMA_BURST: go to CPU_PRI, clear `burst_cnt`; the CPU is granted that same cycle.
- Memory mux:
  - When `dma_gnt`: `mem_a/mem_wd = dma_*`, `mem_we = dma_we`.
  - Otherwise: CPU signals, with `mem_we = cpu_we & cpu_gnt`.
  - Idle (no grant): `mem_we = 0`.
- DMA read data: on an edge with `dma_gnt & ~dma_we`, `dma_rdata <= mem_rd` and `dma_rvalid <= 1`; otherwise `dma_rvalid <= 0` and `dma_rdata` holds.
- Counters are wide enough for their limit. No wrap-around is reachable.

## Timing
- CPU access latency is 0 cycles, identical to a direct `dmem` connection.
- DMA write commits at the edge where `dma_gnt = 1`.
- DMA read: `dma_rvalid` rises 1 cycle after the grant edge.
- DMA must keep `dma_req` and its payload stable until `dma_gnt`. Deasserting earlier withdraws the request; no access occurs.
- Simultaneous requests: resolved by state as above. Never both granted.
- Reset asserted (low), asynchronously:
  - State → `CPU_PRI`.
  - `wait_cnt = burst_cnt = 0`.
  - `dma_rvalid = 0`, `dma_rdata = 0`.
  - While in reset, outputs evaluate for CPU_PRI with zero counters.
- Reset mid-burst: the in-flight DMA read is dropped (no `dma_rvalid`). Writes already committed stay committed.
- Worst CPU stall is `MAX_BURST` cycles.
- Worst DMA wait is `STARVE_LIMIT` cycles of CPU traffic.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_t` enum {`CPU_PRI`, `DMA_BURST`}.
  - Default `STARVE_LIMIT` / `MAX_BURST` constants.
  - Counter-width function (`$clog2`-based).
- One sub-module `arb_cnt`: loadable clear/increment counter with terminal-count compare. Instantiated twice, for wait and burst.
- Mux and grant logic stay in the top module.

## Test plan
- Reset, then idle: all outputs 0 except `cpu_rdata = mem_rd` and `mem_a = cpu_addr`. State is CPU_PRI.
- CPU `sw` to 0x10 with no DMA: `mem_we = 1`, `mem_a = 0x10`, `cpu_stall = 0`. DMA idle throughout.
- DMA read of 0x20 with the CPU idle:
  - `dma_gnt` in the same cycle.
  - Next cycle `dma_rvalid = 1`, `dma_rdata` = preloaded 0xDEADBEEF.
- Continuous `cpu_req` and `dma_req`, defaults (4/4):
  - CPU granted 4 cycles, then DMA granted 4 cycles with `cpu_stall = 1`, repeating.
  - Never both granted.
- DMA drops `dma_req` after 2 burst grants: return to CPU_PRI, with the CPU granted in that same cycle.
- Assert reset mid-burst during a DMA read: `dma_rvalid` stays 0, state is CPU_PRI, counters are 0. Normal arbitration resumes after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the CPU/DMA data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    CPU_PRI   = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_MAX_BURST    = 4;

  // A counter that runs 0..limit-1 needs at least one bit even for limit 1.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/arb_cnt.sv
// Clear/increment counter with a terminal-count flag at LIMIT-1.
module arb_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned W     = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the CPU data port and a DMA master;
// CPU wins by default, with a starvation counter forcing bounded DMA bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 32,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  arb_state_t    state_q, state_d;
  logic          cpu_gnt;
  logic          wait_inc, wait_clr, wait_tc, starve_hit;
  logic          burst_inc, burst_clr, burst_tc, burst_end;
  logic          dma_rvalid_q, dma_rvalid_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  always_comb begin
    if (state_q == DMA_BURST) begin
      dma_gnt = dma_req;
      cpu_gnt = cpu_req & ~dma_req;
    end else begin
      cpu_gnt = cpu_req;
      dma_gnt = dma_req & ~cpu_req;
    end
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // In a burst dma_gnt tracks dma_req, so the limit check needs only burst_tc.
  always_comb begin
    wait_inc   = (state_q == CPU_PRI) & dma_req & cpu_gnt;
    starve_hit = wait_inc & wait_tc;
    wait_clr   = dma_gnt | starve_hit | (state_q != CPU_PRI);
    burst_inc  = (state_q == DMA_BURST) & dma_gnt;
    burst_end  = (state_q == DMA_BURST) & (~dma_req | burst_tc);
    burst_clr  = burst_end | (state_q != DMA_BURST);
    state_d    = state_q;
    if (starve_hit) begin
      state_d = DMA_BURST;
    end else if (burst_end) begin
      state_d = CPU_PRI;
    end
  end

  arb_cnt #(.LIMIT(STARVE_LIMIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .tc    (wait_tc)
  );

  arb_cnt #(.LIMIT(MAX_BURST)) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (burst_clr),
    .inc   (burst_inc),
    .tc    (burst_tc)
  );

  always_comb begin
    if (dma_gnt) begin
      mem_a  = dma_addr;
      mem_wd = dma_wdata;
      mem_we = dma_we;
    end else begin
      mem_a  = cpu_addr;
      mem_wd = cpu_wdata;
      mem_we = cpu_we & cpu_gnt;
    end
    dma_rvalid_d = dma_gnt & ~dma_we;
    dma_rdata_d  = dma_rvalid_d ? mem_rd : dma_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CPU_PRI;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu_rdata  = mem_rd;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule
